// File: rtl/pipeline_scheduler.sv
// ---------------------------------------------------------------------------
// pipeline_scheduler
//
// Purpose:
//   Arbitrates four requesters onto a two-stage (FILTER -> COMPARE) pipeline.
//   A winning requester is chosen round-robin, and the FILTER and COMPARE
//   stages are then enabled in turn. The requester receives a one-cycle ack
//   pulse on success, or a one-cycle err pulse if either stage exceeds its
//   cycle budget. Every output comes straight from a flop.
//
// Parameters:
//   TIMEOUT_CYC    - max cycles allowed in each of FILTER and COMPARE
//
// Ports:
//   clk            in   1  rising-edge clock
//   reset_n        in   1  asynchronous active-low reset
//   req            in   4  per-requester level request
//   filter_done    in   1  filter stage completion pulse
//   compare_done   in   1  compare stage completion pulse
//   filter_enable  out  1  filter stage enable
//   compare_enable out  1  compare stage enable
//   grant_id       out  2  requester owning the pipeline (valid while busy)
//   busy           out  1  high in every state except IDLE
//   ack            out  4  one-hot completion pulse
//   err            out  4  one-hot timeout pulse
//   txn_count      out  8  successful transaction count, wraps 255 -> 0
// ---------------------------------------------------------------------------
module pipeline_scheduler #(
  parameter logic [7:0] TIMEOUT_CYC = 8'd200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] req,
  input  logic       filter_done,
  input  logic       compare_done,
  output logic       filter_enable,
  output logic       compare_enable,
  output logic [1:0] grant_id,
  output logic       busy,
  output logic [3:0] ack,
  output logic [3:0] err,
  output logic [7:0] txn_count
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILTER  = 2'd1,
    ST_COMPARE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  // Round-robin pick: returns {found, index}. The search starts one past the
  // previous winner, so the previous winner has the lowest priority.
  function automatic logic [2:0] rr_pick(input logic [3:0] req_in,
                                         input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 0; i < 4; i++) begin
      idx = last + 2'(i + 1);
      if ((res[2] == 1'b0) && req_in[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Converts a requester index into its one-hot response vector.
  function automatic logic [3:0] onehot4(input logic [1:0] id);
    return 4'b0001 << id;
  endfunction

  state_t     state_q, state_d;
  logic       filter_enable_q, filter_enable_d;
  logic       compare_enable_q, compare_enable_d;
  logic [1:0] grant_id_q, grant_id_d;
  logic [1:0] last_grant_q, last_grant_d;
  logic       busy_q, busy_d;
  logic [3:0] ack_q, ack_d;
  logic [3:0] err_q, err_d;
  logic [7:0] txn_count_q, txn_count_d;
  logic [7:0] tmo_cnt_q, tmo_cnt_d;

  logic [2:0] pick_s;
  logic       tmo_hit_s;

  assign pick_s    = rr_pick(req, last_grant_q);
  // Fires on the last permitted cycle of a stage; a done on that same
  // cycle is checked first and therefore takes precedence.
  assign tmo_hit_s = (tmo_cnt_q == (TIMEOUT_CYC - 8'd1));

  // Next-state and next-output logic for the scheduler FSM.
  always_comb begin
    state_d          = state_q;
    filter_enable_d  = filter_enable_q;
    compare_enable_d = compare_enable_q;
    grant_id_d       = grant_id_q;
    last_grant_d     = last_grant_q;
    txn_count_d      = txn_count_q;
    tmo_cnt_d        = tmo_cnt_q;
    ack_d            = 4'b0000;
    err_d            = 4'b0000;

    case (state_q)
      ST_IDLE: begin
        if (pick_s[2]) begin
          grant_id_d      = pick_s[1:0];
          last_grant_d    = pick_s[1:0];
          filter_enable_d = 1'b1;
          tmo_cnt_d       = 8'd0;
          state_d         = ST_FILTER;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_FILTER: begin
        // compare_done is deliberately not looked at here.
        if (filter_done) begin
          filter_enable_d  = 1'b0;
          compare_enable_d = 1'b1;
          tmo_cnt_d        = 8'd0;
          state_d          = ST_COMPARE;
        end else if (tmo_hit_s) begin
          filter_enable_d = 1'b0;
          err_d           = onehot4(grant_id_q);
          state_d         = ST_RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end

      ST_COMPARE: begin
        if (compare_done) begin
          compare_enable_d = 1'b0;
          ack_d            = onehot4(grant_id_q);
          txn_count_d      = txn_count_q + 8'd1;
          state_d          = ST_RESP;
        end else if (tmo_hit_s) begin
          compare_enable_d = 1'b0;
          err_d            = onehot4(grant_id_q);
          state_d          = ST_RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end

      ST_RESP: begin
        // ack/err were raised on entry; their defaults clear them here.
        state_d = ST_IDLE;
      end

      default: begin
        state_d          = ST_IDLE;
        filter_enable_d  = 1'b0;
        compare_enable_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset leaves req[0] with top priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= ST_IDLE;
      filter_enable_q  <= 1'b0;
      compare_enable_q <= 1'b0;
      grant_id_q       <= 2'd0;
      last_grant_q     <= 2'd3;
      busy_q           <= 1'b0;
      ack_q            <= 4'b0000;
      err_q            <= 4'b0000;
      txn_count_q      <= 8'd0;
      tmo_cnt_q        <= 8'd0;
    end else begin
      state_q          <= state_d;
      filter_enable_q  <= filter_enable_d;
      compare_enable_q <= compare_enable_d;
      grant_id_q       <= grant_id_d;
      last_grant_q     <= last_grant_d;
      busy_q           <= busy_d;
      ack_q            <= ack_d;
      err_q            <= err_d;
      txn_count_q      <= txn_count_d;
      tmo_cnt_q        <= tmo_cnt_d;
    end
  end

  assign filter_enable  = filter_enable_q;
  assign compare_enable = compare_enable_q;
  assign grant_id       = grant_id_q;
  assign busy           = busy_q;
  assign ack            = ack_q;
  assign err            = err_q;
  assign txn_count      = txn_count_q;

endmodule

// File: tb/tb_pipeline_scheduler.sv
// ---------------------------------------------------------------------------
// tb_pipeline_scheduler
//
// Directed bench for pipeline_scheduler with TIMEOUT_CYC = 5. Inputs are
// driven and outputs sampled 1 ns after each rising clock edge.
// ---------------------------------------------------------------------------
module tb_pipeline_scheduler;

  logic       clk;
  logic       reset_n;
  logic [3:0] req;
  logic       filter_done;
  logic       compare_done;
  logic       filter_enable;
  logic       compare_enable;
  logic [1:0] grant_id;
  logic       busy;
  logic [3:0] ack;
  logic [3:0] err;
  logic [7:0] txn_count;

  int n_assert = 0;
  int n_fail   = 0;

  pipeline_scheduler #(.TIMEOUT_CYC(8'd5)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req            (req),
    .filter_done    (filter_done),
    .compare_done   (compare_done),
    .filter_enable  (filter_enable),
    .compare_enable (compare_enable),
    .grant_id       (grant_id),
    .busy           (busy),
    .ack            (ack),
    .err            (err),
    .txn_count      (txn_count)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and on mismatch counts and reports it.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and check the always-true exclusivity properties.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("enables_exclusive", {31'd0, filter_enable & compare_enable}, 32'd0);
    chk("ack_err_onehot", {31'd0, ($countones(ack | err) <= 1)}, 32'd1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  // A full successful transaction with immediate done pulses; req is held.
  task automatic run_txn(input logic [1:0] exp_gid, input logic [7:0] exp_txn);
    tick();
    chk("rr_grant_id", {30'd0, grant_id}, {30'd0, exp_gid});
    chk("rr_fe", {31'd0, filter_enable}, 32'd1);
    filter_done = 1'b1;
    tick();
    filter_done = 1'b0;
    chk("rr_ce", {31'd0, compare_enable}, 32'd1);
    compare_done = 1'b1;
    tick();
    compare_done = 1'b0;
    chk("rr_ack", {28'd0, ack}, {28'd0, (4'b0001 << exp_gid)});
    chk("rr_err", {28'd0, err}, 32'd0);
    chk("rr_txn", {24'd0, txn_count}, {24'd0, exp_txn});
    tick();
    chk("rr_ack_clear", {28'd0, ack}, 32'd0);
    chk("rr_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int fe_cycles;
    int acks;
    int cycles;

    reset_n      = 1'b0;
    req          = 4'b0000;
    filter_done  = 1'b0;
    compare_done = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_fe", {31'd0, filter_enable}, 32'd0);
    chk("rst_ce", {31'd0, compare_enable}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ack", {28'd0, ack}, 32'd0);
    chk("rst_err", {28'd0, err}, 32'd0);
    chk("rst_gid", {30'd0, grant_id}, 32'd0);
    chk("rst_txn", {24'd0, txn_count}, 32'd0);
    reset_n = 1'b1;
    tick();
    chk("idle_no_req", {31'd0, busy}, 32'd0);

    // Single request from requester 2, filter 3 cycles, compare 2 cycles
    req = 4'b0100;
    tick();
    chk("single_fe", {31'd0, filter_enable}, 32'd1);
    chk("single_busy", {31'd0, busy}, 32'd1);
    chk("single_gid", {30'd0, grant_id}, 32'd2);
    chk("single_ce0", {31'd0, compare_enable}, 32'd0);
    tick();
    tick();
    filter_done = 1'b1;
    tick();
    filter_done = 1'b0;
    chk("single_fe_off", {31'd0, filter_enable}, 32'd0);
    chk("single_ce_on", {31'd0, compare_enable}, 32'd1);
    tick();
    compare_done = 1'b1;
    tick();
    compare_done = 1'b0;
    chk("single_ack", {28'd0, ack}, 32'h4);
    chk("single_ce_off", {31'd0, compare_enable}, 32'd0);
    chk("single_txn", {24'd0, txn_count}, 32'd1);
    chk("single_resp_busy", {31'd0, busy}, 32'd1);
    req = 4'b0000;
    tick();
    chk("single_ack_clear", {28'd0, ack}, 32'd0);
    chk("single_idle", {31'd0, busy}, 32'd0);

    // Stray done pulses in IDLE change nothing
    filter_done  = 1'b1;
    compare_done = 1'b1;
    tick();
    filter_done  = 1'b0;
    compare_done = 1'b0;
    chk("stray_busy", {31'd0, busy}, 32'd0);
    chk("stray_fe", {31'd0, filter_enable}, 32'd0);
    chk("stray_ce", {31'd0, compare_enable}, 32'd0);
    chk("stray_ack", {28'd0, ack}, 32'd0);
    chk("stray_txn", {24'd0, txn_count}, 32'd1);

    // Both dones together in FILTER: only the move to COMPARE happens
    req = 4'b0001;
    tick();
    chk("both_gid", {30'd0, grant_id}, 32'd0);
    filter_done  = 1'b1;
    compare_done = 1'b1;
    tick();
    filter_done  = 1'b0;
    compare_done = 1'b0;
    chk("both_ce", {31'd0, compare_enable}, 32'd1);
    chk("both_fe", {31'd0, filter_enable}, 32'd0);
    chk("both_no_ack", {28'd0, ack}, 32'd0);

    // Done on the final permitted COMPARE cycle beats the timeout
    repeat (4) tick();
    chk("edge_ce_still", {31'd0, compare_enable}, 32'd1);
    compare_done = 1'b1;
    tick();
    compare_done = 1'b0;
    chk("done_wins_ack", {28'd0, ack}, 32'h1);
    chk("done_wins_err", {28'd0, err}, 32'd0);
    chk("done_wins_txn", {24'd0, txn_count}, 32'd2);
    req = 4'b0000;
    tick();

    // FILTER timeout: enable high exactly 5 cycles, err replaces ack
    do_reset();
    req = 4'b0001;
    tick();
    fe_cycles = 0;
    while (filter_enable === 1'b1 && fe_cycles < 20) begin
      fe_cycles++;
      tick();
    end
    chk("tmo_fe_cycles", fe_cycles, 32'd5);
    chk("tmo_err", {28'd0, err}, 32'h1);
    chk("tmo_ack", {28'd0, ack}, 32'd0);
    chk("tmo_txn", {24'd0, txn_count}, 32'd0);
    chk("tmo_ce", {31'd0, compare_enable}, 32'd0);
    req = 4'b0000;
    tick();
    chk("tmo_err_clear", {28'd0, err}, 32'd0);
    chk("tmo_idle", {31'd0, busy}, 32'd0);
    req = 4'b0010;
    run_txn(2'd1, 8'd1);
    req = 4'b0000;

    // COMPARE timeout
    req = 4'b0100;
    tick();
    filter_done = 1'b1;
    tick();
    filter_done = 1'b0;
    repeat (4) tick();
    chk("ctmo_ce_still", {31'd0, compare_enable}, 32'd1);
    tick();
    chk("ctmo_ce_off", {31'd0, compare_enable}, 32'd0);
    chk("ctmo_err", {28'd0, err}, 32'h4);
    chk("ctmo_txn", {24'd0, txn_count}, 32'd1);
    req = 4'b0000;
    tick();

    // Fairness with all four requesting: 0,1,2,3,0
    do_reset();
    req = 4'b1111;
    run_txn(2'd0, 8'd1);
    run_txn(2'd1, 8'd2);
    run_txn(2'd2, 8'd3);
    run_txn(2'd3, 8'd4);
    run_txn(2'd0, 8'd5);
    req = 4'b0000;

    // Reset during COMPARE
    req = 4'b0001;
    tick();
    filter_done = 1'b1;
    tick();
    filter_done = 1'b0;
    chk("mid_ce_on", {31'd0, compare_enable}, 32'd1);
    reset_n = 1'b0;
    req     = 4'b1000;
    #1;
    chk("mid_ce_async", {31'd0, compare_enable}, 32'd0);
    chk("mid_busy_async", {31'd0, busy}, 32'd0);
    tick();
    chk("mid_no_ack", {28'd0, ack}, 32'd0);
    chk("mid_no_err", {28'd0, err}, 32'd0);
    chk("mid_txn", {24'd0, txn_count}, 32'd0);
    reset_n = 1'b1;
    tick();
    chk("mid_regrant_gid", {30'd0, grant_id}, 32'd3);
    chk("mid_regrant_fe", {31'd0, filter_enable}, 32'd1);
    filter_done = 1'b1;
    tick();
    filter_done  = 1'b0;
    compare_done = 1'b1;
    tick();
    compare_done = 1'b0;
    chk("mid_ack", {28'd0, ack}, 32'h8);
    req = 4'b0000;
    tick();

    // Wrap of txn_count after 256 successes
    do_reset();
    req          = 4'b0001;
    filter_done  = 1'b1;
    compare_done = 1'b1;
    acks         = 0;
    cycles       = 0;
    while (acks < 255 && cycles < 2000) begin
      tick();
      cycles++;
      if (ack !== 4'b0000) acks++;
    end
    chk("wrap_acks_255", acks, 32'd255);
    chk("wrap_txn_255", {24'd0, txn_count}, 32'd255);
    while (acks < 256 && cycles < 2000) begin
      tick();
      cycles++;
      if (ack !== 4'b0000) acks++;
    end
    chk("wrap_acks_256", acks, 32'd256);
    chk("wrap_txn_0", {24'd0, txn_count}, 32'd0);
    req          = 4'b0000;
    filter_done  = 1'b0;
    compare_done = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_scheduler.md
PIPELINE_SCHEDULER -- requirements
Module: pipeline_scheduler

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 8'd200, the max cycles allowed in each of the FILTER and COMPARE phases.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port req  input  4  per-requester level request, held high until ack or err.
REQ-005 The block SHALL have port filter_done  input  1  filter stage completion pulse.
REQ-006 The block SHALL have port compare_done  input  1  compare stage completion pulse.
REQ-007 The block SHALL have port filter_enable  output  1  filter stage enable, registered.
REQ-008 The block SHALL have port compare_enable  output  1  compare stage enable, registered.
REQ-009 The block SHALL have port grant_id  output  2  index of the requester owning the pipeline, valid while busy.
REQ-010 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 The block SHALL have port ack  output  4  one-hot, one-cycle completion pulse.
REQ-012 The block SHALL have port err  output  4  one-hot, one-cycle timeout pulse.
REQ-013 The block SHALL have port txn_count  output  8  count of successful transactions, wraps 255->0.

Function
REQ-014 The FSM SHALL have four states, IDLE, FILTER, COMPARE and RESP, with all outputs registered.
REQ-015 In IDLE with req!=0, the block SHALL grant round-robin: search last_grant+1, +2, +3, +4 (mod 4), pick the first set bit, load grant_id and last_grant, set filter_enable=1, and go to FILTER.
REQ-016 Grant latency SHALL be 1 cycle: req sampled high at edge N means filter_enable=1 and busy=1 after edge N.
REQ-017 In FILTER, on filter_done=1 the block SHALL set filter_enable=0 and compare_enable=1 and go to COMPARE, with no idle cycle between the enables.
REQ-018 In COMPARE, on compare_done=1 the block SHALL set compare_enable=0, set ack[grant_id]=1, increment txn_count, and go to RESP.
REQ-019 RESP SHALL last exactly 1 cycle: ack returns to 0 and the FSM returns to IDLE; the requester deasserts req on the edge where it samples ack=1.
REQ-020 The timeout counter (8-bit) SHALL clear on entry to FILTER and COMPARE and increment each cycle in those states.
REQ-021 When the timeout counter equals TIMEOUT_CYC-1 with no done input, the block SHALL drop both enables, pulse err[grant_id] for 1 cycle, leave txn_count unchanged, and go to RESP, so err replaces ack.
REQ-022 When done and timeout occur in the same cycle, done SHALL win.
REQ-023 The block SHALL ignore filter_done outside FILTER and compare_done outside COMPARE, including both asserted together in FILTER (only the filter transition occurs).
REQ-024 The block SHALL not abort a transaction on a req drop mid-transaction; it completes and ack/err still pulses.
REQ-025 At most one bit of ack|err SHALL be high in any cycle, and filter_enable and compare_enable SHALL never both be high.

Reset
REQ-026 While reset_n=0, independent of clk, the block SHALL force state=IDLE, filter_enable=0, compare_enable=0, busy=0, ack=0, err=0, grant_id=0, txn_count=0, timeout counter=0, and last_grant=3, so req[0] has top priority after reset.
REQ-027 Reset asserted mid-transaction SHALL drop the enables immediately and produce no ack/err pulse; after deassertion the block SHALL re-arbitrate from IDLE.

Verification
REQ-028 Single request: req=4'b0100; filter_done 3 cycles after filter_enable, compare_done 2 cycles after compare_enable -> grant_id=2, one ack=4'b0100 pulse, txn_count=1.
REQ-029 Fairness: req=4'b1111 held, each transaction served -> grant order 0,1,2,3,0 and exactly one ack per transaction.
REQ-030 Timeout: TIMEOUT_CYC=5, req=4'b0001, filter_done never asserted -> filter_enable high exactly 5 cycles, err=4'b0001 pulse, txn_count=0, next request then serviced normally.
REQ-031 Simultaneous/stray done: filter_done and compare_done together in FILTER -> only COMPARE entered; compare_done pulsed in IDLE -> no state change.
REQ-032 Reset mid-COMPARE: reset_n=0 for 1 cycle -> compare_enable=0 asynchronously, no ack, and after release req=4'b1000 pending is granted with grant_id=3.
REQ-033 Wrap: 256 successful transactions -> txn_count returns to 0.
